// File: rtl/if_fetch_stage.sv
// if_fetch_stage: instruction-fetch stage of the 5-stage MIPS32 pipeline.
// Owns the PC, fetches from a combinational instruction ROM and loads the
// IF/ID pipeline register. It handles stall, flush and branch/jump redirects,
// and halts fetch once the PC runs past the end of the ROM.
// Optional build macro FETCH_PERF_CNT_EN adds the fetch and bubble counters.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] ADDR_LIMIT = 32'd32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic [31:0] pc,
    input  logic [31:0] imem_instruction,
    output logic [31:0] if_id_pc4,
    output logic [31:0] if_id_instruction,
    output logic        if_id_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] bubble_count
`endif
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        PEND = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_d;
    logic [31:0] pend_q, pend_d;
    logic [31:0] pc_plus4;
    logic [31:0] raw_target;
    logic [31:0] target;
    logic        redirect;
    logic        load_valid;
    logic        load_bubble;

    // Redirect selection and next-state / next-PC decision.
    // The branch target takes priority over the jump target.
    // Flush is applied last so that it overrides both hold and capture.
    always_comb begin
        redirect    = branch_taken | jump;
        raw_target  = branch_taken ? branch_target : jump_target;
        target      = {raw_target[31:2], 2'b00};
        pc_plus4    = pc + 32'd4;
        state_d     = state_q;
        pc_d        = pc;
        pend_d      = pend_q;
        load_valid  = 1'b0;
        load_bubble = 1'b0;
        case (state_q)
            RUN: begin
                if (stall) begin
                    if (redirect) begin
                        pend_d  = target;
                        state_d = PEND;
                    end
                end else if (redirect) begin
                    pc_d        = target;
                    load_bubble = 1'b1;
                end else if (pc < ADDR_LIMIT) begin
                    pc_d       = pc_plus4;
                    load_valid = 1'b1;
                end else begin
                    load_bubble = 1'b1;
                    state_d     = HALT;
                end
            end
            PEND: begin
                // The oldest redirect is kept. New requests are ignored until the stall releases.
                if (!stall) begin
                    pc_d        = pend_q;
                    load_bubble = 1'b1;
                    state_d     = RUN;
                end
            end
            HALT: begin
                if (redirect) begin
                    pc_d        = target;
                    load_bubble = 1'b1;
                    state_d     = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
        if (flush) begin
            load_bubble = 1'b1;
            load_valid  = 1'b0;
        end
    end

    // State, PC and pending-target registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= RUN;
            pc      <= RESET_PC;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            pc      <= pc_d;
            pend_q  <= pend_d;
        end
    end

    // IF/ID pipeline register: load a bubble, capture a fetched word, or hold.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if_id_pc4         <= '0;
            if_id_instruction <= '0;
            if_id_valid       <= 1'b0;
        end else if (load_bubble) begin
            if_id_pc4         <= '0;
            if_id_instruction <= '0;
            if_id_valid       <= 1'b0;
        end else if (load_valid) begin
            if_id_pc4         <= pc_plus4;
            if_id_instruction <= imem_instruction;
            if_id_valid       <= 1'b1;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Performance counters for valid captures and bubble loads. Both wrap at 2^32.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_count  <= '0;
            bubble_count <= '0;
        end else begin
            if (load_valid) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (load_bubble) begin
                bubble_count <= bubble_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed self-checking bench for if_fetch_stage.
// It uses a 32-byte ROM in which rom[i] = 32'h2001_0001 + i * 32'h0001_0001.
module tb_if_fetch_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] pc;
    logic [31:0] imem_instruction;
    logic [31:0] if_id_pc4;
    logic [31:0] if_id_instruction;
    logic        if_id_valid;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] bubble_count;
`endif

    logic [31:0] rom [0:7];
    logic [96:0] obs;
    int unsigned checks;
    int unsigned errors;

    if_fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .ADDR_LIMIT(32'd32)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .flush            (flush),
        .branch_taken     (branch_taken),
        .branch_target    (branch_target),
        .jump             (jump),
        .jump_target      (jump_target),
        .pc               (pc),
        .imem_instruction (imem_instruction),
        .if_id_pc4        (if_id_pc4),
        .if_id_instruction(if_id_instruction),
        .if_id_valid      (if_id_valid)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count      (fetch_count),
        .bubble_count     (bubble_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational instruction ROM. Out-of-range addresses return a marker word.
    always_comb begin
        if (pc < 32'd32) imem_instruction = rom[pc[4:2]];
        else             imem_instruction = 32'hDEAD_BEEF;
    end

    assign obs = {pc, if_id_pc4, if_id_instruction, if_id_valid};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step();
        step();
        checks++;
        if (obs !== {32'h0, 32'h0, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got %h want %h", obs, {32'h0, 32'h0, 32'h0, 1'b0});
        end
`ifdef FETCH_PERF_CNT_EN
        checks++;
        if ({fetch_count, bubble_count} !== 64'h0) begin
            errors++;
            $display("FAIL reset_counters: got %h %h want 0 0", fetch_count, bubble_count);
        end
`endif
    endtask

    task automatic test_first_fetch();
        reset = 1'b1;
        checks++;
        if (obs !== {32'h0, 32'h0, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL first_cycle1: got %h want %h", obs, {32'h0, 32'h0, 32'h0, 1'b0});
        end
        step();
        checks++;
        if (obs !== {32'h4, 32'h4, 32'h2001_0001, 1'b1}) begin
            errors++;
            $display("FAIL first_cycle2: got %h want %h", obs, {32'h4, 32'h4, 32'h2001_0001, 1'b1});
        end
    endtask

    task automatic test_sequential_halt();
        for (int unsigned i = 0; i < 7; i++) step();
        checks++;
        if (obs !== {32'd32, 32'd32, 32'h2008_0008, 1'b1}) begin
            errors++;
            $display("FAIL seq_last_word: got %h want %h", obs, {32'd32, 32'd32, 32'h2008_0008, 1'b1});
        end
        step();
        checks++;
        if (obs !== {32'd32, 32'h0, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL halt_enter: got %h want %h", obs, {32'd32, 32'h0, 32'h0, 1'b0});
        end
        step();
        checks++;
        if (obs !== {32'd32, 32'h0, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL halt_hold: got %h want %h", obs, {32'd32, 32'h0, 32'h0, 1'b0});
        end
        // Stall is asserted along with the jump. HALT must ignore it.
        jump        = 1'b1;
        jump_target = 32'd8;
        stall       = 1'b1;
        step();
        jump  = 1'b0;
        stall = 1'b0;
        checks++;
        if (obs !== {32'd8, 32'h0, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL halt_jump: got %h want %h", obs, {32'd8, 32'h0, 32'h0, 1'b0});
        end
        step();
        checks++;
        if (obs !== {32'd12, 32'd12, 32'h2003_0003, 1'b1}) begin
            errors++;
            $display("FAIL halt_resume: got %h want %h", obs, {32'd12, 32'd12, 32'h2003_0003, 1'b1});
        end
    endtask

    task automatic test_stall_flush();
        stall = 1'b1;
        step();
        checks++;
        if (obs !== {32'd12, 32'd12, 32'h2003_0003, 1'b1}) begin
            errors++;
            $display("FAIL stall_hold: got %h want %h", obs, {32'd12, 32'd12, 32'h2003_0003, 1'b1});
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++;
        if (obs !== {32'd12, 32'h0, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL stall_flush: got %h want %h", obs, {32'd12, 32'h0, 32'h0, 1'b0});
        end
        step();
        stall = 1'b0;
        checks++;
        if (obs !== {32'd12, 32'h0, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL stall_after_flush: got %h want %h", obs, {32'd12, 32'h0, 32'h0, 1'b0});
        end
        step();
        checks++;
        if (obs !== {32'd16, 32'd16, 32'h2004_0004, 1'b1}) begin
            errors++;
            $display("FAIL stall_release: got %h want %h", obs, {32'd16, 32'd16, 32'h2004_0004, 1'b1});
        end
        step();
    endtask

    task automatic test_stall_redirect();
        stall         = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 32'h10;
        step();
        branch_taken = 1'b0;
        checks++;
        if (obs !== {32'd20, 32'd20, 32'h2005_0005, 1'b1}) begin
            errors++;
            $display("FAIL pend_enter: got %h want %h", obs, {32'd20, 32'd20, 32'h2005_0005, 1'b1});
        end
        jump        = 1'b1;
        jump_target = 32'h04;
        step();
        jump  = 1'b0;
        stall = 1'b0;
        checks++;
        if (obs !== {32'd20, 32'd20, 32'h2005_0005, 1'b1}) begin
            errors++;
            $display("FAIL pend_hold: got %h want %h", obs, {32'd20, 32'd20, 32'h2005_0005, 1'b1});
        end
        step();
        checks++;
        if (obs !== {32'h10, 32'h0, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL pend_release: got %h want %h", obs, {32'h10, 32'h0, 32'h0, 1'b0});
        end
        step();
        checks++;
        if (obs !== {32'h14, 32'h14, 32'h2005_0005, 1'b1}) begin
            errors++;
            $display("FAIL pend_after: got %h want %h", obs, {32'h14, 32'h14, 32'h2005_0005, 1'b1});
        end
    endtask

    task automatic test_simultaneous();
        branch_taken  = 1'b1;
        branch_target = 32'h18;
        jump          = 1'b1;
        jump_target   = 32'h1C;
        step();
        jump = 1'b0;
        checks++;
        if (obs !== {32'h18, 32'h0, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL branch_priority: got %h want %h", obs, {32'h18, 32'h0, 32'h0, 1'b0});
        end
        branch_target = 32'h1A;
        step();
        branch_taken = 1'b0;
        checks++;
        if (obs !== {32'h18, 32'h0, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL target_align: got %h want %h", obs, {32'h18, 32'h0, 32'h0, 1'b0});
        end
        step();
        checks++;
        if (obs !== {32'h1C, 32'h1C, 32'h2007_0007, 1'b1}) begin
            errors++;
            $display("FAIL redirect_fetch: got %h want %h", obs, {32'h1C, 32'h1C, 32'h2007_0007, 1'b1});
        end
    endtask

    task automatic test_reset_in_pend();
        stall       = 1'b1;
        jump        = 1'b1;
        jump_target = 32'd8;
        step();
        jump  = 1'b0;
        reset = 1'b0;
        stall = 1'b0;
        step();
        checks++;
        if (obs !== {32'h0, 32'h0, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL pend_reset: got %h want %h", obs, {32'h0, 32'h0, 32'h0, 1'b0});
        end
`ifdef FETCH_PERF_CNT_EN
        checks++;
        if ({fetch_count, bubble_count} !== 64'h0) begin
            errors++;
            $display("FAIL pend_reset_counters: got %h %h want 0 0", fetch_count, bubble_count);
        end
`endif
        reset = 1'b1;
        step();
        checks++;
        if (obs !== {32'h4, 32'h4, 32'h2001_0001, 1'b1}) begin
            errors++;
            $display("FAIL pend_reset_resume: got %h want %h", obs, {32'h4, 32'h4, 32'h2001_0001, 1'b1});
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        reset         = 1'b0;
        stall         = 1'b0;
        flush         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = '0;
        jump          = 1'b0;
        jump_target   = '0;
        for (int unsigned i = 0; i < 8; i++) rom[i] = 32'h2001_0001 + i * 32'h0001_0001;
        test_reset();
        test_first_fetch();
        test_sequential_halt();
        test_stall_flush();
        test_stall_redirect();
        test_simultaneous();
        test_reset_in_pend();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
